// File: rtl/qr_pkg.sv
// Shared QR datapath definitions: default widths, FSM state encoding shared by
// the iterative arithmetic units (Multiply/Divide), and saturation limits.
package qr_pkg;

  localparam int unsigned QR_I_DATA_W = 16;
  localparam int unsigned QR_O_DATA_W = 16;
  localparam int unsigned QR_FRAC_W   = 12;

  // Saturation limits for the default result width
  localparam logic signed [QR_O_DATA_W-1:0] QR_SAT_MAX = {1'b0, {(QR_O_DATA_W-1){1'b1}}};
  localparam logic signed [QR_O_DATA_W-1:0] QR_SAT_MIN = {1'b1, {(QR_O_DATA_W-1){1'b0}}};

  // Handshake FSM shared by the iterative units
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } qr_state_t;

endpackage

// File: rtl/round_sat.sv
// round_sat: combinational fixed-point renormalisation of an unsigned magnitude.
// Rounds half away from zero while dropping FRAC_W bits, applies the sign and
// saturates to the signed O_DATA_W range.
//  i_mag       in   IN_W      unsigned magnitude with 2*FRAC_W fractional bits
//  i_neg       in   1         result is negative
//  o_result_c  out  O_DATA_W  signed, rounded, saturated result (combinational)
module round_sat #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned O_DATA_W = 16,
  parameter int unsigned FRAC_W   = 12
) (
  input  logic [IN_W-1:0]            i_mag,
  input  logic                       i_neg,
  output logic signed [O_DATA_W-1:0] o_result_c
);

  localparam int unsigned SUM_W = IN_W + 1;

  localparam logic [SUM_W-1:0] HALF_LSB = SUM_W'(1) << (FRAC_W - 1);
  localparam logic [SUM_W-1:0] POS_LIM  = SUM_W'({(O_DATA_W-1){1'b1}});
  localparam logic [SUM_W-1:0] NEG_LIM  = POS_LIM + SUM_W'(1);

  localparam logic signed [O_DATA_W-1:0] SAT_MAX = {1'b0, {(O_DATA_W-1){1'b1}}};
  localparam logic signed [O_DATA_W-1:0] SAT_MIN = {1'b1, {(O_DATA_W-1){1'b0}}};

  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_mag;
  logic [O_DATA_W-1:0] w_trunc;

  // Rounding on the magnitude gives round-half-away-from-zero after the sign is applied
  assign w_sum   = {1'b0, i_mag} + HALF_LSB;
  assign w_mag   = w_sum >> FRAC_W;
  assign w_trunc = O_DATA_W'(w_mag);

  always_comb begin
    o_result_c = SAT_MAX;
    if (i_neg) begin
      if (w_mag > NEG_LIM) o_result_c = SAT_MIN;
      else                 o_result_c = signed'(~w_trunc + O_DATA_W'(1));
    end else begin
      if (w_mag > POS_LIM) o_result_c = SAT_MAX;
      else                 o_result_c = signed'(w_trunc);
    end
  end

endmodule

// File: rtl/seq_multiply.sv
// seq_multiply: iterative signed fixed-point multiplier (radix-2 shift-add on
// magnitudes), same en/fin handshake as the Divide unit.
//  i_clk    in   1         clock, rising edge
//  i_rst_n  in   1         asynchronous reset, active low
//  en       in   1         start request, sampled in IDLE or DONE
//  a        in   I_DATA_W  signed multiplicand
//  b        in   I_DATA_W  signed multiplier
//  fin      out  1         one-cycle result-valid pulse
//  result   out  O_DATA_W  signed product, held until the next completion
module seq_multiply
  import qr_pkg::*;
#(
  parameter int unsigned I_DATA_W = QR_I_DATA_W,
  parameter int unsigned O_DATA_W = QR_O_DATA_W,
  parameter int unsigned FRAC_W   = QR_FRAC_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       en,
  input  logic signed [I_DATA_W-1:0] a,
  input  logic signed [I_DATA_W-1:0] b,
  output logic                       fin,
  output logic signed [O_DATA_W-1:0] result
);

  localparam int unsigned CNT_W = $clog2(I_DATA_W);
  localparam int unsigned ACC_W = 2 * I_DATA_W;

  qr_state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0]           r_acc, w_acc_nxt;
  logic [I_DATA_W-1:0]        r_a_mag, w_a_mag_nxt;
  logic [I_DATA_W-1:0]        r_b_mag, w_b_mag_nxt;
  logic                       r_sign, w_sign_nxt;
  logic                       r_fin, w_fin_nxt;
  logic signed [O_DATA_W-1:0] r_result, w_result_nxt;

  logic [I_DATA_W-1:0]        w_a_abs, w_b_abs;
  logic signed [O_DATA_W-1:0] w_rs_result;

  // Unsigned magnitudes: the most negative operand maps exactly to 2^(W-1)
  assign w_a_abs = a[I_DATA_W-1] ? (~a + I_DATA_W'(1)) : a;
  assign w_b_abs = b[I_DATA_W-1] ? (~b + I_DATA_W'(1)) : b;

  round_sat #(
    .IN_W     (ACC_W),
    .O_DATA_W (O_DATA_W),
    .FRAC_W   (FRAC_W)
  ) u_round_sat (
    .i_mag      (r_acc),
    .i_neg      (r_sign),
    .o_result_c (w_rs_result)
  );

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_sign   <= 1'b0;
      r_fin    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_a_mag  <= w_a_mag_nxt;
      r_b_mag  <= w_b_mag_nxt;
      r_sign   <= w_sign_nxt;
      r_fin    <= w_fin_nxt;
      r_result <= w_result_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_a_mag_nxt  = r_a_mag;
    w_b_mag_nxt  = r_b_mag;
    w_sign_nxt   = r_sign;
    w_fin_nxt    = 1'b0;
    w_result_nxt = r_result;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (en) begin
          w_a_mag_nxt = w_a_abs;
          w_b_mag_nxt = w_b_abs;
          w_sign_nxt  = a[I_DATA_W-1] ^ b[I_DATA_W-1];
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_b_mag[r_cnt]) w_acc_nxt = r_acc + (ACC_W'(r_a_mag) << r_cnt);
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(I_DATA_W - 1)) w_state_nxt = ST_NORM;
      end
      ST_NORM: begin
        w_result_nxt = w_rs_result;
        w_fin_nxt    = 1'b1;
        w_state_nxt  = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fin    = r_fin;
  assign result = r_result;

endmodule

// File: tb/tb_seq_multiply.sv
module tb_seq_multiply;

  logic               i_clk;
  logic               i_rst_n;
  logic               en;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               fin;
  logic signed [15:0] result;

  int n_tests;
  int n_fail;

  seq_multiply dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en      (en),
    .a       (a),
    .b       (b),
    .fin     (fin),
    .result  (result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Driver: start one op, scramble operands after accept, return result and edge count to fin
  task automatic run_op(input logic signed [15:0] va, input logic signed [15:0] vb,
                        output logic signed [15:0] res, output int lat);
    @(negedge i_clk);
    en = 1'b1; a = va; b = vb;
    @(posedge i_clk);
    #1;
    en = 1'b0; a = 16'sh5a5a; b = -16'sd77;
    lat = -1;
    res = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk);
      #1;
      if (fin) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; en = 1'b0; a = '0; b = '0;
    #12;
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL reset_fin got=%b exp=0", fin); end
    n_tests++;
    if (result !== 16'sd0) begin n_fail++; $display("FAIL reset_result got=%0d exp=0", result); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic signed [15:0] r;
    int lat;
    run_op(16'sd4096, 16'sd2048, r, lat);
    n_tests++;
    if (lat !== 17) begin n_fail++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    n_tests++;
    if (r !== 16'sd2048) begin n_fail++; $display("FAIL basic_1x0.5 got=%0d exp=2048", r); end
    @(posedge i_clk); #1;
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL basic_fin_width got=%b exp=0", fin); end
    n_tests++;
    if (result !== 16'sd2048) begin n_fail++; $display("FAIL basic_hold got=%0d exp=2048", result); end
    run_op(-16'sd5066, 16'sd10028, r, lat);
    n_tests++;
    if (r !== -16'sd12403) begin n_fail++; $display("FAIL basic_neg_round got=%0d exp=-12403", r); end
    run_op(16'sd0, -16'sd1234, r, lat);
    n_tests++;
    if (r !== 16'sd0 || lat !== 17) begin
      n_fail++; $display("FAIL basic_zero got=%0d lat=%0d exp=0 lat=17", r, lat);
    end
  endtask

  task automatic test_rounding();
    logic signed [15:0] va [3] = '{16'sd1, -16'sd1, 16'sd1};
    logic signed [15:0] vb [3] = '{16'sd2048, 16'sd2048, 16'sd2047};
    logic signed [15:0] ex [3] = '{16'sd1, -16'sd1, 16'sd0};
    logic signed [15:0] r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], r, lat);
      n_tests++;
      if (r !== ex[i]) begin
        n_fail++; $display("FAIL round_%0d a=%0d b=%0d got=%0d exp=%0d", i, va[i], vb[i], r, ex[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] va [3] = '{16'sd32767, -16'sd32768, -16'sd32768};
    logic signed [15:0] vb [3] = '{16'sd32767, 16'sd32767, -16'sd32768};
    logic signed [15:0] ex [3] = '{16'sd32767, -16'sd32768, 16'sd32767};
    logic signed [15:0] r;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], r, lat);
      n_tests++;
      if (r !== ex[i]) begin
        n_fail++; $display("FAIL sat_%0d a=%0d b=%0d got=%0d exp=%0d", i, va[i], vb[i], r, ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pos [$];
    @(negedge i_clk);
    en = 1'b1; a = 16'sd4096; b = 16'sd2048;
    for (int c = 1; c <= 60; c++) begin
      @(posedge i_clk);
      #1;
      if (fin) pos.push_back(c);
      if (pos.size() > 0) begin
        n_tests++;
        if (result !== 16'sd2048) begin
          n_fail++; $display("FAIL b2b_result c=%0d got=%0d exp=2048", c, result);
        end
      end
    end
    n_tests++;
    if (pos.size() != 3) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=3", pos.size());
    end else begin
      n_tests++;
      if (pos[0] != 18 || pos[1] != 36 || pos[2] != 54) begin
        n_fail++; $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=18,36,54", pos[0], pos[1], pos[2]);
      end
    end
    @(negedge i_clk);
    en = 1'b0;
    repeat (25) @(posedge i_clk);
  endtask

  task automatic test_ignore_en();
    int nfin = 0;
    int first = -1;
    logic signed [15:0] r = '0;
    @(negedge i_clk);
    en = 1'b1; a = -16'sd5066; b = 16'sd10028;
    @(posedge i_clk);
    #1;
    en = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge i_clk);
      #1;
      if (c == 3) begin en = 1'b1; a = 16'sd4096; b = 16'sd4096; end
      if (c == 4) en = 1'b0;
      if (fin) begin
        nfin++;
        if (first < 0) begin first = c; r = result; end
      end
    end
    n_tests++;
    if (nfin != 1 || first != 17) begin
      n_fail++; $display("FAIL ignore_en_fins got=%0d at=%0d exp=1 at=17", nfin, first);
    end
    n_tests++;
    if (r !== -16'sd12403) begin n_fail++; $display("FAIL ignore_en_result got=%0d exp=-12403", r); end
  endtask

  task automatic test_reset_mid();
    int nfin = 0;
    logic signed [15:0] r;
    int lat;
    @(negedge i_clk);
    en = 1'b1; a = 16'sd4096; b = 16'sd2048;
    @(posedge i_clk);
    #1;
    en = 1'b0;
    repeat (5) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (fin !== 1'b0 || result !== 16'sd0) begin
      n_fail++; $display("FAIL rst_mid got fin=%b result=%0d exp fin=0 result=0", fin, result);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge i_clk);
      #1;
      if (fin) nfin++;
    end
    n_tests++;
    if (nfin != 0) begin n_fail++; $display("FAIL rst_mid_stale_fin got=%0d exp=0", nfin); end
    run_op(16'sd4096, 16'sd2048, r, lat);
    n_tests++;
    if (r !== 16'sd2048 || lat !== 17) begin
      n_fail++; $display("FAIL rst_mid_recover got=%0d lat=%0d exp=2048 lat=17", r, lat);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_ignore_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
